vram_fetch_arbiter: RTL

Shares one synchronous-read video RAM between the tile fetch engine and a CPU port.
- Slots are scheduled from the sync generator's hpos/vpos beam counters.
- Each 8-pixel cell gets two fixed video slots: a name-table read, then a pattern read for the next cell.
- All other cycles go to the CPU through a req/ack handshake. Output pattern bytes feed the pixel shifter.

---
 rtl/vram_fetch_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares one sync-read VRAM between tile fetch and CPU.
// Video takes the name/pattern address slots of each 8-pixel cell; the CPU
// gets every other cycle through req/ack. Ports: clk, reset (sync, high),
// hpos/vpos beam counters, cpu_req/we/addr/wdata -> cpu_ack/rdata/rvalid,
// mem_addr/we/wdata -> VRAM, mem_rdata <- VRAM, pat_data/col/valid -> shifter.
// Option: define VRAM_STALL_STATS_EN to add the cpu_stall_cnt[15:0] output.
module vram_fetch_arbiter #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] NAME_BASE = 12'h000,
  parameter logic [ADDR_W-1:0] PAT_BASE = 12'h800,
  parameter int V_DISPLAY = 240,
  parameter int V_MAX = 261,
  parameter int H_PREFETCH = 304
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pat_data,
  output logic [4:0]        pat_col,
  output logic              pat_valid
`ifdef VRAM_STALL_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  localparam logic [8:0] VDISP = 9'(V_DISPLAY);
  localparam logic [8:0] VMAX = 9'(V_MAX);
  localparam logic [8:0] HP0 = 9'(H_PREFETCH);
  localparam logic [8:0] HP3 = 9'(H_PREFETCH + 3);

  logic [8:0]        fline;
  logic [4:0]        col;
  logic [2:0]        phase;
  logic              live;
  logic              in_win;
  logic              name_slot;
  logic              pat_slot;
  logic              grant;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tile;
  logic              tile_ok;
  logic              name_issued;
  logic              pat_issued;
  logic              rd_pend;
  logic [7:0]        rdata_q;
  logic [7:0]        pat_q;
  logic [4:0]        col_q;

  // After hpos 256 the fetcher works on the following line.
  always_comb begin
    fline = vpos;
    if (hpos >= 9'd256) begin
      fline = (vpos == VMAX) ? 9'd0 : vpos + 9'd1;
    end
  end

  assign col = (hpos < 9'd248) ? hpos[7:3] + 5'd1 : 5'd0;
  assign phase = hpos[2:0];
  assign live = !reset;

  assign in_win = (fline < VDISP) &&
                  ((hpos < 9'd248) ||
                   ((hpos >= HP0) && (hpos <= HP3)));

  assign name_slot = live && in_win && (phase == 3'd0);
  assign pat_slot = live && in_win && (phase == 3'd2);
  assign grant = live && cpu_req && !name_slot && !pat_slot;

  always_comb begin
    mem_addr = addr_q;
    if (name_slot) begin
      mem_addr = NAME_BASE + ADDR_W'({fline[7:3], col});
    end else if (pat_slot) begin
      mem_addr = PAT_BASE + ADDR_W'({tile, fline[2:0]});
    end else if (grant) begin
      mem_addr = cpu_addr;
    end
  end

  assign mem_we = grant && cpu_we;
  assign mem_wdata = grant ? cpu_wdata : 8'd0;
  assign cpu_ack = grant;

  // Read data arrives the cycle after its address; pass it straight
  // through on the valid cycle and hold it afterwards.
  assign cpu_rvalid = live && rd_pend;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : rdata_q;

  assign pat_valid = live && pat_issued && in_win && (phase == 3'd3);
  assign pat_data = pat_valid ? mem_rdata : pat_q;
  assign pat_col = pat_valid ? col : col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      tile <= 8'd0;
      tile_ok <= 1'b0;
      name_issued <= 1'b0;
      pat_issued <= 1'b0;
      rd_pend <= 1'b0;
      rdata_q <= 8'd0;
      pat_q <= 8'd0;
      col_q <= 5'd0;
    end else begin
      addr_q <= mem_addr;
      name_issued <= name_slot;
      // A tile is only trusted when its name read was issued on the
      // previous cycle; a beam jump drops it until the next phase 0.
      if (in_win && (phase == 3'd1) && name_issued) begin
        tile <= mem_rdata;
        tile_ok <= 1'b1;
      end else if (name_slot || pat_slot) begin
        tile_ok <= 1'b0;
      end
      pat_issued <= pat_slot && tile_ok;
      rd_pend <= grant && !cpu_we;
      if (cpu_rvalid) begin
        rdata_q <= mem_rdata;
      end
      if (pat_valid) begin
        pat_q <= mem_rdata;
        col_q <= col;
      end
    end
  end

`ifdef VRAM_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || ((vpos == 9'd0) && (hpos == 9'd0))) begin
      cpu_stall_cnt <= 16'd0;
    end else if (cpu_req && !cpu_ack && (cpu_stall_cnt != 16'hFFFF)) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
